// File: rtl/sys_io_pkg.sv
// Shared types and helpers for the sys_io input decoders.
`timescale 1ns/1ps
package sys_io_pkg;

  localparam logic [7:0] START_CHAR_DEFAULT = 8'd83;

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StButtons,
    StAxes,
    StCheck
  } frame_state_e;

  function automatic int unsigned nb_bytes(input int unsigned n);
    return (n + 7) / 8;
  endfunction

  // Saturating increment for counters up to 32 bits wide. Callers zero-extend into val
  // and truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: counts cycles since the last clear and pulses once on expiry.
`timescale 1ns/1ps
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic en_in,
  output logic expired_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    // A clear on the terminal cycle suppresses expiry: the byte wins.
    expired_out = en_in && !clr_in && (cnt_q == CntMax);
    cnt_d       = cnt_q;
    if (clr_in || expired_out) begin
      cnt_d = '0;
    end else if (en_in) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controller_frame_rx.sv
// Decodes framed, XOR-checksummed controller packets from a byte stream and commits each
// controller's buttons/axes atomically when the checksum matches.
`timescale 1ns/1ps
module controller_frame_rx
  import sys_io_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned NUM_BUTTONS     = 8,
  parameter int unsigned NUM_AXES        = 2,
  parameter logic [7:0]  START_CHAR      = START_CHAR_DEFAULT,
  parameter logic [7:0]  AXIS_RESET      = 8'd128,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned ERR_W           = 8
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [7:0]                            byte_in,
  input  logic                                  byte_valid_in,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*NUM_AXES*8-1:0]  axes_out,
  output logic [NUM_CONTROLLERS-1:0]             update_out,
  output logic                                  busy_out,
  output logic [ERR_W-1:0]                      csum_err_out,
  output logic [ERR_W-1:0]                      id_err_out,
  output logic [ERR_W-1:0]                      timeout_err_out
);

  localparam int unsigned NB     = nb_bytes(NUM_BUTTONS);
  localparam int unsigned BtnW   = NB * 8;
  localparam int unsigned AxW    = NUM_AXES * 8;
  localparam int unsigned IdW    = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;
  localparam int unsigned MaxCnt = (NB > NUM_AXES) ? NB : NUM_AXES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  frame_state_e state_q, state_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic [BtnW-1:0] btn_sh_q, btn_sh_d;
  logic [AxW-1:0]  ax_sh_q, ax_sh_d;
  logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic [NUM_CONTROLLERS*AxW-1:0]         axes_q, axes_d;
  logic [NUM_CONTROLLERS-1:0]             update_q, update_d;
  logic [ERR_W-1:0] csum_err_q, csum_err_d, id_err_q, id_err_d, tmo_err_q, tmo_err_d;
  logic expired;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clr_in     (byte_valid_in || (state_q == StIdle)),
    .en_in      (state_q != StIdle),
    .expired_out(expired)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    btn_sh_d   = btn_sh_q;
    ax_sh_d    = ax_sh_q;
    buttons_d  = buttons_q;
    axes_d     = axes_q;
    update_d   = '0;
    csum_err_d = csum_err_q;
    id_err_d   = id_err_q;
    tmo_err_d  = tmo_err_q;

    if (byte_valid_in) begin
      unique case (state_q)
        StIdle: begin
          if (byte_in == START_CHAR) state_d = StId;
        end
        StId: begin
          if (32'(byte_in) < NUM_CONTROLLERS) begin
            id_d    = IdW'(byte_in);
            csum_d  = byte_in;
            cnt_d   = '0;
            state_d = StButtons;
          end else begin
            id_err_d = ERR_W'(sat_inc(32'(id_err_q), ERR_W));
            state_d  = StIdle;
          end
        end
        StButtons: begin
          // MSB byte first: shift left so the last byte lands in the low bits.
          btn_sh_d = BtnW'({btn_sh_q, byte_in});
          csum_d   = csum_q ^ byte_in;
          if (cnt_q == CntW'(NB - 1)) begin
            cnt_d   = '0;
            state_d = StAxes;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StAxes: begin
          ax_sh_d[int'(cnt_q)*8 +: 8] = byte_in;
          csum_d = csum_q ^ byte_in;
          if (cnt_q == CntW'(NUM_AXES - 1)) begin
            cnt_d   = '0;
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCheck: begin
          if (byte_in == csum_q) begin
            buttons_d[int'(id_q)*NUM_BUTTONS +: NUM_BUTTONS] = btn_sh_q[NUM_BUTTONS-1:0];
            axes_d[int'(id_q)*AxW +: AxW] = ax_sh_q;
            update_d[id_q] = 1'b1;
          end else begin
            csum_err_d = ERR_W'(sat_inc(32'(csum_err_q), ERR_W));
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (expired) begin
      state_d   = StIdle;
      cnt_d     = '0;
      btn_sh_d  = '0;
      ax_sh_d   = '0;
      tmo_err_d = ERR_W'(sat_inc(32'(tmo_err_q), ERR_W));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      id_q       <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      btn_sh_q   <= '0;
      ax_sh_q    <= '0;
      buttons_q  <= '0;
      axes_q     <= {(NUM_CONTROLLERS*NUM_AXES){AXIS_RESET}};
      update_q   <= '0;
      csum_err_q <= '0;
      id_err_q   <= '0;
      tmo_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      btn_sh_q   <= btn_sh_d;
      ax_sh_q    <= ax_sh_d;
      buttons_q  <= buttons_d;
      axes_q     <= axes_d;
      update_q   <= update_d;
      csum_err_q <= csum_err_d;
      id_err_q   <= id_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign buttons_out     = buttons_q;
  assign axes_out        = axes_q;
  assign update_out      = update_q;
  assign busy_out        = (state_q != StIdle);
  assign csum_err_out    = csum_err_q;
  assign id_err_out      = id_err_q;
  assign timeout_err_out = tmo_err_q;

endmodule

// File: tb/tb_controller_frame_rx.sv
// Bench for controller_frame_rx: two configurations driven independently, checked every
// cycle against a frame-level model, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_controller_frame_rx;

  localparam int NC    = 2;
  localparam int NBTN0 = 8;
  localparam int NAX0  = 2;
  localparam int NBTN1 = 12;
  localparam int NAX1  = 3;
  localparam int TO    = 16;
  localparam logic [7:0] SC = 8'd83;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] bd0 = 8'h00, bd1 = 8'h00;
  logic       bv0 = 1'b0, bv1 = 1'b0;

  logic [NC*NBTN0-1:0]  buttons0;
  logic [NC*NAX0*8-1:0] axes0;
  logic [NC-1:0]        update0;
  logic                 busy0;
  logic [7:0]           cerr0, ierr0, terr0;
  logic [NC*NBTN1-1:0]  buttons1;
  logic [NC*NAX1*8-1:0] axes1;
  logic [NC-1:0]        update1;
  logic                 busy1;
  logic [7:0]           cerr1, ierr1, terr1;

  always #5 clk = ~clk;

  controller_frame_rx #(
    .NUM_CONTROLLERS(NC), .NUM_BUTTONS(NBTN0), .NUM_AXES(NAX0), .TIMEOUT_CYCLES(TO), .ERR_W(8)
  ) dut0 (
    .clk_in(clk), .rst_in(rst), .byte_in(bd0), .byte_valid_in(bv0),
    .buttons_out(buttons0), .axes_out(axes0), .update_out(update0), .busy_out(busy0),
    .csum_err_out(cerr0), .id_err_out(ierr0), .timeout_err_out(terr0)
  );

  controller_frame_rx #(
    .NUM_CONTROLLERS(NC), .NUM_BUTTONS(NBTN1), .NUM_AXES(NAX1), .TIMEOUT_CYCLES(TO), .ERR_W(8)
  ) dut1 (
    .clk_in(clk), .rst_in(rst), .byte_in(bd1), .byte_valid_in(bv1),
    .buttons_out(buttons1), .axes_out(axes1), .update_out(update1), .busy_out(busy1),
    .csum_err_out(cerr1), .id_err_out(ierr1), .timeout_err_out(terr1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  int         m_btn[2][NC];
  int         m_ax[2][NC][3];
  logic [NC-1:0] m_upd[2];
  bit         m_busy[2];
  int         m_cerr[2], m_ierr[2], m_terr[2];
  logic [7:0] fb[2][8];
  int         fn[2];
  bit         inf[2];
  int         gap[2];

  function automatic int nbtn_of(input int k); return (k == 0) ? NBTN0 : NBTN1; endfunction
  function automatic int nax_of(input int k);  return (k == 0) ? NAX0 : NAX1;   endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NC; c++) begin
        m_btn[k][c] = 0;
        for (int a = 0; a < 3; a++) m_ax[k][c][a] = 128;
      end
      m_upd[k] = '0; m_busy[k] = 0;
      m_cerr[k] = 0; m_ierr[k] = 0; m_terr[k] = 0;
      fn[k] = 0; inf[k] = 0; gap[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic [7:0] b);
    int nb, na, tot, id, bits;
    logic [7:0] x;
    nb = (nbtn_of(k) + 7) / 8;
    na = nax_of(k);
    tot = 1 + nb + na + 1;
    m_upd[k] = '0;
    if (v) begin
      gap[k] = 0;
      if (!inf[k]) begin
        if (b == SC) begin inf[k] = 1; fn[k] = 0; end
      end else begin
        fb[k][fn[k]] = b;
        fn[k]++;
        if (fn[k] == 1 && int'(b) >= NC) begin
          if (m_ierr[k] < 255) m_ierr[k]++;
          inf[k] = 0;
        end else if (fn[k] == tot) begin
          x = 8'h00;
          for (int i = 0; i < tot - 1; i++) x ^= fb[k][i];
          if (x == b) begin
            id = int'(fb[k][0]);
            bits = 0;
            for (int i = 1; i <= nb; i++) bits = (bits << 8) | int'(fb[k][i]);
            m_btn[k][id] = bits & ((1 << nbtn_of(k)) - 1);
            for (int a = 0; a < na; a++) m_ax[k][id][a] = int'(fb[k][1 + nb + a]);
            m_upd[k][id] = 1'b1;
          end else if (m_cerr[k] < 255) begin
            m_cerr[k]++;
          end
          inf[k] = 0;
        end
      end
    end else if (inf[k]) begin
      gap[k]++;
      if (gap[k] == TO) begin
        if (m_terr[k] < 255) m_terr[k]++;
        inf[k] = 0;
      end
    end
    m_busy[k] = inf[k];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, bv0, bd0);
      model_step(1, bv1, bd1);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NC*NBTN0-1:0]  eb0;
  logic [NC*NAX0*8-1:0] ea0;
  logic [NC*NBTN1-1:0]  eb1;
  logic [NC*NAX1*8-1:0] ea1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        eb0[c*NBTN0 +: NBTN0] = NBTN0'(m_btn[0][c]);
        eb1[c*NBTN1 +: NBTN1] = NBTN1'(m_btn[1][c]);
        for (int a = 0; a < NAX0; a++) ea0[(c*NAX0+a)*8 +: 8] = 8'(m_ax[0][c][a]);
        for (int a = 0; a < NAX1; a++) ea1[(c*NAX1+a)*8 +: 8] = 8'(m_ax[1][c][a]);
      end
      chk("d0 buttons", 64'(buttons0), 64'(eb0));
      chk("d0 axes", 64'(axes0), 64'(ea0));
      chk("d0 update", 64'(update0), 64'(m_upd[0]));
      chk("d0 busy", 64'(busy0), 64'(m_busy[0]));
      chk("d0 csum_err", 64'(cerr0), 64'(m_cerr[0]));
      chk("d0 id_err", 64'(ierr0), 64'(m_ierr[0]));
      chk("d0 timeout_err", 64'(terr0), 64'(m_terr[0]));
      chk("d1 buttons", 64'(buttons1), 64'(eb1));
      chk("d1 axes", 64'(axes1), 64'(ea1));
      chk("d1 update", 64'(update1), 64'(m_upd[1]));
      chk("d1 busy", 64'(busy1), 64'(m_busy[1]));
      chk("d1 csum_err", 64'(cerr1), 64'(m_cerr[1]));
      chk("d1 id_err", 64'(ierr1), 64'(m_ierr[1]));
      chk("d1 timeout_err", 64'(terr1), 64'(m_terr[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input logic v, input logic [7:0] b);
    @(negedge clk);
    if (k == 0) begin bv0 = v; bd0 = b; end
    else begin bv1 = v; bd1 = b; end
  endtask

  task automatic put(input int k, input logic [7:0] b);
    drive(k, 1'b1, b);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) drive(k, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic rand_traffic(input int k, input int nfr);
    logic [7:0] fr[8];
    logic [7:0] cs;
    int len, r, g;
    len = 1 + (nbtn_of(k) + 7) / 8 + nax_of(k) + 1;
    for (int f = 0; f < nfr; f++) begin
      r = $urandom_range(0, 9);
      fr[0] = (r == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, NC - 1));
      cs = fr[0];
      for (int i = 1; i < len - 1; i++) begin
        fr[i] = 8'($urandom);
        cs ^= fr[i];
      end
      fr[len-1] = (r == 1) ? (cs ^ 8'h10) : cs;
      put(k, SC);
      for (int i = 0; i < len; i++) begin
        g = $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) g = TO - 1;
        if (r == 2 && i == len / 2) g = TO + $urandom_range(0, 3);
        idle(k, g);
        put(k, fr[i]);
      end
      idle(k, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        put(k, 8'($urandom));
        idle(k, 1);
      end
    end
    idle(k, TO + 4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset buttons0", 64'(buttons0), 64'h0);
    chk("reset axes0", 64'(axes0), 64'h8080_8080);
    chk("reset busy0", 64'(busy0), 64'h0);
    chk("reset axes1", 64'(axes1), 64'h8080_8080_8080);

    // Good frame for controller 1.
    put(0, SC); put(0, 8'h01); put(0, 8'hA5); put(0, 8'h10); put(0, 8'h20); put(0, 8'h94);
    idle(0, 1);
    chk("commit buttons0", 64'(buttons0), 64'hA500);
    chk("commit axes0", 64'(axes0), 64'h2010_8080);
    chk("commit update0", 64'(update0), 64'h2);
    idle(0, 1);
    chk("update one-shot", 64'(update0), 64'h0);

    // Bad checksum: nothing committed.
    put(0, SC); put(0, 8'h01); put(0, 8'h11); put(0, 8'h22); put(0, 8'h33); put(0, 8'h95);
    idle(0, 1);
    chk("badcsum buttons0", 64'(buttons0), 64'hA500);
    chk("badcsum csum_err", 64'(cerr0), 64'h1);
    chk("badcsum update0", 64'(update0), 64'h0);

    // Out-of-range ID, then a good frame for controller 0.
    put(0, SC); put(0, 8'h02); idle(0, 1);
    chk("id_err count", 64'(ierr0), 64'h1);
    chk("id_err idle", 64'(busy0), 64'h0);
    put(0, SC); put(0, 8'h00); put(0, 8'h3C); put(0, 8'h01); put(0, 8'h02); put(0, 8'h3F);
    idle(0, 1);
    chk("ctrl0 buttons0", 64'(buttons0), 64'hA53C);
    chk("ctrl0 axes0", 64'(axes0), 64'h2010_0201);
    chk("ctrl0 update0", 64'(update0), 64'h1);

    // Stall mid-frame, then a frame whose bytes arrive on the last allowed cycle.
    put(0, SC); put(0, 8'h00); put(0, 8'h01); idle(0, 20);
    chk("timeout count", 64'(terr0), 64'h1);
    chk("timeout idle", 64'(busy0), 64'h0);
    put(0, SC); idle(0, TO - 1); put(0, 8'h01); idle(0, TO - 1); put(0, 8'h5A);
    idle(0, TO - 1); put(0, 8'h00); idle(0, TO - 1); put(0, 8'hFF);
    idle(0, TO - 1); put(0, 8'hA4); idle(0, 1);
    chk("edge buttons0", 64'(buttons0), 64'h5A3C);
    chk("edge no timeout", 64'(terr0), 64'h1);
    chk("edge update0", 64'(update0), 64'h2);

    // Wider configuration: 12 buttons, 3 axes, back-to-back frames.
    put(1, SC); put(1, 8'h00); put(1, 8'h0F); put(1, 8'hAB);
    put(1, 8'h01); put(1, 8'h02); put(1, 8'h03); put(1, 8'hA4);
    put(1, SC); put(1, 8'h01); put(1, 8'h00); put(1, 8'h00);
    put(1, 8'h00); put(1, 8'h00); put(1, 8'h00); put(1, 8'h01);
    idle(1, 1);
    chk("wide buttons1", 64'(buttons1), 64'h00_0FAB);
    chk("wide axes1", 64'(axes1), 64'h00_0000_03_0201);
    chk("wide update1", 64'(update1), 64'h2);

    // Reset in the middle of a frame.
    put(0, SC); put(0, 8'h01); idle(0, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst buttons0", 64'(buttons0), 64'h0);
    chk("midrst axes0", 64'(axes0), 64'h8080_8080);
    chk("midrst busy0", 64'(busy0), 64'h0);
    chk("midrst timeout_err", 64'(terr0), 64'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    idle(0, 1);
    chk("midrst update0", 64'(update0), 64'h0);

    // Saturation of the checksum error counter.
    repeat (300) begin
      put(0, SC); put(0, 8'h00); put(0, 8'h00); put(0, 8'h00); put(0, 8'h00); put(0, 8'h01);
    end
    idle(0, 1);
    chk("csum_err saturate", 64'(cerr0), 64'hFF);

    do_reset();
    fork
      rand_traffic(0, 300);
      rand_traffic(1, 300);
    join
    idle(0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/controller_frame_rx.md
Name: controller_frame_rx

Overview:
- Parametrised successor to the single-controller SPI input decoder.
- Consumes the byte stream from the existing SPI byte receiver and decodes framed, checksummed packets for up to NUM_CONTROLLERS controllers, each with configurable button and axis counts.
- Commits each controller's state atomically, only when the frame checksum passes.
- Drops stalled frames by inter-byte timeout and keeps saturating error counters for debug.
- Sits between the SPI byte receiver and game-logic consumers, inside the sys_io subsystem.

Parameters:
NUM_CONTROLLERS, 2, number of controller channels; ID byte range 0..NUM_CONTROLLERS-1
NUM_BUTTONS, 8, buttons per controller; carried in NB = ceil(NUM_BUTTONS/8) bytes
NUM_AXES, 2, 8-bit analogue axes per controller
START_CHAR, 83, frame start byte
AXIS_RESET, 128, reset/centre value of every axis
TIMEOUT_CYCLES, 100000, maximum clk_in cycles between bytes inside a frame
ERR_W, 8, width of each error counter

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
byte_in  input  8  received byte
byte_valid_in  input  1  single-cycle strobe qualifying byte_in
buttons_out  output  NUM_CONTROLLERS*NUM_BUTTONS  committed buttons; controller c occupies slice [c*NUM_BUTTONS +: NUM_BUTTONS]
axes_out  output  NUM_CONTROLLERS*NUM_AXES*8  committed axes; controller c, axis a at [(c*NUM_AXES+a)*8 +: 8]
update_out  output  NUM_CONTROLLERS  one-cycle pulse on the bit of the controller just committed
busy_out  output  1  high while a frame is in progress (state != IDLE)
csum_err_out  output  ERR_W  count of checksum failures, saturating
id_err_out  output  ERR_W  count of frames with an out-of-range ID, saturating
timeout_err_out  output  ERR_W  count of inter-byte timeouts, saturating

Behaviour:
- Frame format: START_CHAR, ID, NB button bytes, NUM_AXES axis bytes, CSUM.
  - Button bytes are MSB byte first; the lowest NUM_BUTTONS bits of the concatenation are used.
  - Axis bytes are sent axis 0 first.
  - CSUM = XOR of ID, all button bytes and all axis bytes.
- Reset (async, on rst_in high):
  - State goes to IDLE.
  - buttons_out=0, axes_out=all axes AXIS_RESET, update_out=0, busy_out=0.
  - All error counters 0; shadow registers, byte counter and timeout counter cleared.
- States:
  - IDLE: a byte equal to START_CHAR goes to ID; all other bytes are ignored.
  - ID: if ID < NUM_CONTROLLERS, latch it, seed the running XOR with ID, go to BUTTONS. Otherwise increment id_err and go to IDLE.
  - BUTTONS: shift each byte into the shadow button register and XOR into the checksum. After NB bytes go to AXES.
  - AXES: write byte k to shadow axis k and XOR into the checksum. After NUM_AXES bytes go to CHECK.
  - CHECK: on the next byte, if it equals the running XOR, commit; else increment csum_err. Go to IDLE in either case.
- States only advance on cycles with byte_valid_in=1. START_CHAR inside a frame is treated as data, never as a resync.
- Commit:
  - Registered; outputs for the latched ID change on the cycle after the CSUM byte is accepted.
  - update_out[ID] is high for exactly that one cycle.
  - Other controllers' outputs are untouched.
  - Shadow registers are never visible on the outputs; a partial frame never alters them.
- Timeout:
  - The counter clears on every byte_valid_in and increments every cycle while state != IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no byte that cycle: go to IDLE, increment timeout_err, discard the shadow registers.
  - If byte_valid_in coincides with the timeout cycle, the byte wins and no timeout is recorded.
  - In IDLE the counter is held at 0.
- Error counters saturate at all-ones and do not wrap.
- Mid-frame reset aborts the frame with no commit and no update pulse.
- Back-to-back frames are accepted: a START_CHAR may arrive on the cycle immediately after CSUM.
- Counter widths are derived with $clog2; no truncation for any legal parameter set with NB+NUM_AXES <= 255.

Decomposition:
- Shared package sys_io_pkg holds:
  - START_CHAR default;
  - the frame-state enum (IDLE, ID, BUTTONS, AXES, CHECK);
  - a function nb_bytes(n) = (n+7)/8;
  - a parametrised-width helper for saturating increment.
- One sub-module, frame_timeout: a counter with clear/enable inputs and an expired pulse, parametrised on TIMEOUT_CYCLES.
- The SPI byte receiver is instantiated by the parent, not inside this block.

Test Plan:
- Defaults, send 83,1,0xA5,0x10,0x20,CSUM=0x1^0xA5^0x10^0x20=0x94 -> one cycle after CSUM: buttons_out[15:8]=0xA5, axes for ctrl1 = 0x10 (axis0), 0x20 (axis1), update_out=2'b10; ctrl0 still 0 / 128.
- Same frame with CSUM=0x95 -> no output change, csum_err_out=1, update_out stays 0.
- ID byte 0x02 (out of range) -> id_err_out=1; state IDLE; the following valid frame for ctrl0 commits normally.
- TIMEOUT_CYCLES=16: send 83,0,0x01 then idle 20 cycles -> timeout_err_out=1, busy_out low. A fresh full frame then commits; a byte arriving exactly on cycle 15 continues the frame with no timeout.
- NUM_BUTTONS=12, NUM_AXES=3: frame 83,0,0x0F,0xAB,1,2,3,CSUM -> buttons_out[11:0]=0xFAB, three axes 1,2,3.
- Assert rst_in mid-frame after the ID byte -> all outputs at reset values, no update pulse. Drive 300 bad-CSUM frames with ERR_W=8 -> csum_err_out saturates at 255.
